gray_counter_sched: RTL and testbench



---
 rtl/gray_sched_pkg.sv | 19 +
 rtl/gray_counter_sched_if.sv | 37 +++
 rtl/gray_step.sv | 52 +++++
 rtl/gray_counter_sched.sv | 126 ++++++++++++
 tb/tb_gray_counter_sched.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_sched_pkg.sv
// Shared definitions for the Gray-code step scheduler: default sizes,
// FSM state encoding and the binary-to-Gray conversion.
package gray_sched_pkg;

  localparam int unsigned DEF_WIDTH = 3;
  localparam int unsigned DEF_LEN_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Reflected binary Gray code; callers cast to their own width (<= 32).
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_counter_sched_if.sv
// Requester-side bundle of the Gray counter scheduler.
//   req/len0/len1/hold (and dir when GRAY_DIR_EN) : requester -> scheduler
//   gnt/busy/done/gray/wrap                        : scheduler -> requester
// master: requester side, slave: scheduler side.
interface gray_counter_sched_if #(
  parameter int unsigned WIDTH = gray_sched_pkg::DEF_WIDTH,
  parameter int unsigned LEN_W = gray_sched_pkg::DEF_LEN_W
);
  logic [1:0]       req;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic             hold;
`ifdef GRAY_DIR_EN
  logic             dir;
`endif
  logic [1:0]       gnt;
  logic             busy;
  logic [1:0]       done;
  logic [WIDTH-1:0] gray;
  logic             wrap;

  modport master (
    output req, len0, len1, hold,
`ifdef GRAY_DIR_EN
    output dir,
`endif
    input  gnt, busy, done, gray, wrap
  );

  modport slave (
    input  req, len0, len1, hold,
`ifdef GRAY_DIR_EN
    input  dir,
`endif
    output gnt, busy, done, gray, wrap
  );
endinterface

// File: rtl/gray_step.sv
// Gray-code step counter: binary register plus registered Gray output.
// Ports: clk, rst_n (sync, active-low), en_i (take one step), dir_i
// (1 = count down), gray_o (registered code), wrap_o (one-cycle pulse when
// a step crosses between the last code and zero).
module gray_step #(
  parameter int unsigned WIDTH = gray_sched_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] gray_o,
  output logic             wrap_o
);
  import gray_sched_pkg::*;

  localparam logic [WIDTH-1:0] LAST_BIN = '1;

  logic [WIDTH-1:0] bin_q, bin_d, gray_q;
  logic             wrap_q, wrap_d;

  // Next binary value and wrap detection for one step.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (en_i) begin
      if (dir_i) begin
        bin_d  = bin_q - WIDTH'(1);
        wrap_d = (bin_q == '0);
      end else begin
        bin_d  = bin_q + WIDTH'(1);
        wrap_d = (bin_q == LAST_BIN);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= WIDTH'(bin2gray(32'(bin_d)));
      wrap_q <= wrap_d;
    end
  end

  assign gray_o = gray_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/gray_counter_sched.sv
// Round-robin scheduler sharing one Gray step counter between two
// requesters. Each granted job steps the counter len times (paused by
// hold), then pulses done to the owner; dropping req aborts the job.
// Ports: clk, rst_n (sync, active-low), sched_io (slave modport:
// req/len0/len1/hold in; gnt/busy/done/gray/wrap out, all registered).
// Optional: GRAY_DIR_EN adds sched_io.dir (1 = count down, latched at grant).
module gray_counter_sched #(
  parameter int unsigned WIDTH = gray_sched_pkg::DEF_WIDTH,
  parameter int unsigned LEN_W = gray_sched_pkg::DEF_LEN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gray_counter_sched_if.slave  sched_io
);
  import gray_sched_pkg::*;

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;   // requester granted most recently
  logic             dir_q, dir_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             owner_c, win_c, dir_in_c, step_en_c;
  logic [LEN_W-1:0] len_win_c;

`ifdef GRAY_DIR_EN
  assign dir_in_c = sched_io.dir;
`else
  assign dir_in_c = 1'b0;
`endif

  assign owner_c   = gnt_q[1];
  // Tie goes to the requester not granted last.
  assign win_c     = (sched_io.req == 2'b11) ? ~last_q : sched_io.req[1];
  assign len_win_c = win_c ? sched_io.len1 : sched_io.len0;

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    done_d    = '0;
    rem_d     = rem_q;
    last_d    = last_q;
    dir_d     = dir_q;
    step_en_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|sched_io.req) begin
          gnt_d  = win_c ? 2'b10 : 2'b01;
          busy_d = 1'b1;
          rem_d  = len_win_c;
          dir_d  = dir_in_c;
          if (len_win_c == '0) begin
            state_d = ST_DONE;
            done_d  = gnt_d;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        // Abort wins over a step in the same cycle.
        if (!sched_io.req[owner_c]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          last_d  = owner_c;
        end else if (!sched_io.hold) begin
          step_en_c = 1'b1;
          rem_d     = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_DONE;
            done_d  = gnt_q;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        last_d  = owner_c;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      last_q  <= 1'b1;
      dir_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
    end
  end

  gray_step #(.WIDTH(WIDTH)) u_step (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (step_en_c),
    .dir_i  (dir_q),
    .gray_o (sched_io.gray),
    .wrap_o (sched_io.wrap)
  );

  assign sched_io.gnt  = gnt_q;
  assign sched_io.busy = busy_q;
  assign sched_io.done = done_q;

endmodule

// File: tb/tb_gray_counter_sched.sv
// Bench for gray_counter_sched: a driver issues jobs and pushes the expected
// completion into a queue; a monitor pops it when done pulses.
module tb_gray_counter_sched;
  localparam int unsigned W  = 3;
  localparam int unsigned LW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gray_counter_sched_if #(.WIDTH(W), .LEN_W(LW)) bus ();

  gray_counter_sched #(.WIDTH(W), .LEN_W(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sched_io (bus)
  );

  typedef struct {
    int owner;
    int gray;
    int wraps;
    int cycles;
  } exp_t;

  exp_t     exp_q[$];
  int       n_cmp = 0;
  int       n_bad = 0;
  int       seq[8] = '{0, 1, 3, 2, 6, 7, 5, 4};  // 3-bit Gray up sequence
  int       m_bin  = 0;                          // model step position
  int       m_last = 1;                          // model last-granted
  bit [1:0] req_v  = 2'b00;

  task automatic chk(input string nm, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    req_v  = 2'b00;
    bus.req = req_v;
    m_bin  = 0;
    m_last = 1;
  endtask

  // kind: 0 normal, 1 abort after kpos steps, 2 reset after kpos steps.
  task automatic run_job(input bit [1:0] r, input int l0, input int l1,
                         input int kind, input int kpos,
                         input bit rnd_hold, input int hmask);
    int w, n, k, stop, steps, holds, e;
    bit got, h;
    bit hv[$];
    req_v    = req_v | r;
    bus.req  = req_v;
    bus.len0 = LW'(l0);
    bus.len1 = LW'(l1);
    bus.hold = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.gnt != 2'b00) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("grant_timeout", 0, 1);
      req_v   = 2'b00;
      bus.req = req_v;
      return;
    end
    w = (req_v == 2'b11) ? (1 - m_last) : int'(req_v[1]);
    n = (w == 1) ? l1 : l0;
    k = kind;
    if (k != 0 && n == 0) k = 0;
    chk("gnt_onehot", int'(bus.gnt), 1 << w);
    chk("busy_at_grant", int'(bus.busy), 1);
    stop  = (k == 0) ? n : (kpos % n);
    steps = 0;
    holds = 0;
    e     = 0;
    while (steps < stop) begin
      h = rnd_hold ? ($urandom % 4 == 0) : (((hmask >> e) & 1) != 0);
      hv.push_back(h);
      if (h) holds++;
      else   steps++;
      e++;
    end
    if (k == 0) begin
      exp_q.push_back('{owner: w, gray: seq[(m_bin + n) % 8],
                        wraps: (m_bin + n) / 8, cycles: n + holds});
    end
    foreach (hv[i]) begin
      bus.hold = hv[i];
      tick();
    end
    bus.hold = 1'b0;
    if (k == 0) begin
      req_v[w] = 1'b0;
      bus.req  = req_v;
      m_bin    = (m_bin + n) % 8;
      m_last   = w;
      tick();
      chk("idle_gap_gnt", int'(bus.gnt), 0);
      chk("idle_gap_busy", int'(bus.busy), 0);
    end else if (k == 1) begin
      req_v[w] = 1'b0;
      bus.req  = req_v;
      bus.hold = 1'($urandom % 2);
      tick();
      bus.hold = 1'b0;
      m_bin    = (m_bin + stop) % 8;
      m_last   = w;
      chk("abort_gnt", int'(bus.gnt), 0);
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_done", int'(bus.done), 0);
      chk("abort_gray", int'(bus.gray), seq[m_bin]);
    end else begin
      rst_n = 1'b0;
      tick();
      chk("rst_gnt", int'(bus.gnt), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_gray", int'(bus.gray), 0);
      chk("rst_wrap", int'(bus.wrap), 0);
      rst_n   = 1'b1;
      req_v   = 2'b00;
      bus.req = req_v;
      m_bin   = 0;
      m_last  = 1;
    end
  endtask

  // Monitor: measures each job from its grant and checks it at done.
  initial begin
    int       cyc;
    int       wr;
    logic [1:0] gprev;
    exp_t     ex;
    cyc   = 0;
    wr    = 0;
    gprev = 2'b00;
    forever begin
      @(posedge clk);
      #2;
      if (bus.gnt != 2'b00 && gprev == 2'b00) begin
        cyc = 0;
        wr  = 0;
      end else begin
        cyc++;
      end
      gprev = bus.gnt;
      if (bus.wrap) begin
        wr++;
        chk("wrap_at_zero", int'(bus.gray), 0);
      end
      if (bus.done != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", int'(bus.done), 0);
        end else begin
          ex = exp_q.pop_front();
          chk("done_owner", int'(bus.done), 1 << ex.owner);
          chk("done_gray", int'(bus.gray), ex.gray);
          chk("done_wraps", wr, ex.wraps);
          chk("done_latency", cyc, ex.cycles);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bus.req  = 2'b00;
    bus.len0 = '0;
    bus.len1 = '0;
    bus.hold = 1'b0;
`ifdef GRAY_DIR_EN
    bus.dir  = 1'b0;
`endif
    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_gnt", int'(bus.gnt), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_gray", int'(bus.gray), 0);
    chk("reset_wrap", int'(bus.wrap), 0);
    rst_n = 1'b1;

    // Single request, len 3: ends at 010.
    run_job(2'b01, 3, 0, 0, 0, 1'b0, 0);
    chk("job1_gray", int'(bus.gray), 2);

    // Tie after reset: requester 0 first, then 1; ends at 110.
    do_reset();
    run_job(2'b11, 2, 2, 0, 0, 1'b0, 0);
    run_job(2'b00, 2, 2, 0, 0, 1'b0, 0);
    chk("tie_gray", int'(bus.gray), 6);

    // Full cycle from 000 with one wrap.
    do_reset();
    run_job(2'b10, 0, 8, 0, 0, 1'b0, 0);
    chk("wrap_job_gray", int'(bus.gray), 0);

    // Hold for two cycles after the first step.
    run_job(2'b01, 4, 0, 0, 0, 1'b0, 32'h6);

    // Abort after 2 of 5 steps from 000 -> 011.
    do_reset();
    run_job(2'b01, 5, 0, 1, 2, 1'b0, 0);
    chk("abort_gray_011", int'(bus.gray), 3);

    // Reset mid-run.
    run_job(2'b01, 5, 0, 2, 2, 1'b0, 0);

    // Zero-length job: gray unchanged, no wrap.
    run_job(2'b01, 3, 0, 0, 0, 1'b0, 0);
    run_job(2'b01, 0, 0, 0, 0, 1'b0, 0);
    chk("len0_gray", int'(bus.gray), 2);

    // Randomized jobs.
    repeat (40) begin
      int kind;
      kind = ($urandom % 8 == 0) ? 1 : (($urandom % 16 == 0) ? 2 : 0);
      run_job(2'($urandom_range(1, 3)), int'($urandom % 16), int'($urandom % 16),
              kind, int'($urandom % 16), 1'b1, 0);
    end

    req_v   = 2'b00;
    bus.req = req_v;
    repeat (4) tick();
    chk("pending_expect", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
